// File: rtl/data_main_memory.sv
// ---------------------------------------------------------------------------
// data_main_memory
// Block-organised backing store behind the data cache. Each access moves one
// 128-bit block and keeps busywait high for LATENCY cycles, followed by a
// single response cycle. After reset the whole array is cleared by a sweep
// that writes one block per cycle.
//
// Ports
//   clock        in   1    single clock, rising edge
//   reset        in   1    synchronous, active-high
//   read         in   1    block read request
//   write        in   1    block write-back request
//   address      in   28   block address; only [DEPTH_BITS-1:0] used
//   writedata    in   128  block to store on write
//   readdata     out  128  registered block returned on read
//   busywait     out  1    request pending or init sweep running
//   illegal_req  out  1    one-cycle pulse: read and write both high in IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | clearing array, one block per cycle; requests ignored
// IDLE  | waiting; a single request here is access cycle 0
// BUSY  | access cycles 1..LATENCY-1, counting down to the response
// RESP  | one-cycle response; memory/readdata updated on the entering edge
// ---------------------------------------------------------------------------
module data_main_memory #(
  parameter int DEPTH_BITS = 8,
  parameter int LATENCY    = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic         write,
  input  logic [27:0]  address,
  input  logic [127:0] writedata,
  output logic [127:0] readdata,
  output logic         busywait,
  output logic         illegal_req
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_BUSY = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int                    NUM_BLOCKS = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS-1:0] PTR_LAST   = '1;
  // Cycle 0 is spent in IDLE, so BUSY covers LATENCY-1 cycles: load LATENCY-2
  // and leave BUSY when the counter reaches zero.
  localparam logic [3:0]            CNT_LOAD   = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic                  LAT_ONE    = (LATENCY == 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEPTH_BITS-1:0] r_ptr;
  logic [3:0]            r_cnt;
  logic [DEPTH_BITS-1:0] r_addr;
  logic [127:0]          r_wdata;
  logic                  r_is_write;
  logic [127:0]          r_readdata;
  logic                  r_illegal;
  logic [127:0]          r_mem [0:NUM_BLOCKS-1];

  logic                  w_start;
  logic                  w_enter_resp;
  logic [DEPTH_BITS-1:0] w_eff_addr;
  logic [127:0]          w_eff_wdata;
  logic                  w_eff_we;
  logic                  w_unused_addr;

  // Upper address bits alias onto the same blocks.
  assign w_unused_addr = ^address[27:DEPTH_BITS];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: if (r_ptr == PTR_LAST) w_state_nxt = S_IDLE;
      S_IDLE: if (read ^ write) w_state_nxt = LAT_ONE ? S_RESP : S_BUSY;
      S_BUSY: begin
        // Dropping both requests abandons the access, even on its last busy cycle.
        if (!read && !write)   w_state_nxt = S_IDLE;
        else if (r_cnt == '0)  w_state_nxt = S_RESP;
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Output / control decode
  always_comb begin
    busywait     = 1'b0;
    w_start      = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_INIT: busywait = 1'b1;
      S_IDLE: begin
        if (read ^ write) begin
          busywait     = 1'b1;
          w_start      = 1'b1;
          w_enter_resp = LAT_ONE;
        end
      end
      S_BUSY: begin
        busywait     = 1'b1;
        w_enter_resp = (read || write) && (r_cnt == '0);
      end
      default: busywait = 1'b0;
    endcase
  end

  // With LATENCY=1 the response edge is also the accept edge, so the live
  // inputs are used there; otherwise the latched copies are.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_eff_addr  = address[DEPTH_BITS-1:0];
      w_eff_wdata = writedata;
      w_eff_we    = write;
    end else begin
      w_eff_addr  = r_addr;
      w_eff_wdata = r_wdata;
      w_eff_we    = r_is_write;
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_readdata <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= (r_state == S_IDLE) && read && write;
      if (r_state == S_INIT) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (w_start) begin
        r_addr     <= address[DEPTH_BITS-1:0];
        r_wdata    <= writedata;
        r_is_write <= write;
        r_cnt      <= CNT_LOAD;
      end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_enter_resp && !w_eff_we) begin
        r_readdata <= r_mem[w_eff_addr];
      end
    end
  end

  // Storage array: cleared by the sweep, never by reset directly. A write that
  // coincides with a reset edge is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == S_INIT) begin
        r_mem[r_ptr] <= '0;
      end else if (w_enter_resp && w_eff_we) begin
        r_mem[w_eff_addr] <= w_eff_wdata;
      end
    end
  end

  assign readdata    = r_readdata;
  assign illegal_req = r_illegal;

endmodule

// File: tb/tb_data_main_memory.sv
module tb_data_main_memory;

  localparam int LAT = 4;
  localparam int DB  = 8;

  logic         clk = 1'b0;
  logic         reset, read, write;
  logic [27:0]  address;
  logic [127:0] writedata, readdata;
  logic         busywait, illegal_req;

  logic         reset1, read1, write1;
  logic [27:0]  address1;
  logic [127:0] writedata1, readdata1;
  logic         busywait1, illegal_req1;

  always #5 clk = ~clk;

  data_main_memory #(.DEPTH_BITS(DB), .LATENCY(LAT)) dut (
    .clock(clk), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .illegal_req(illegal_req)
  );

  data_main_memory #(.DEPTH_BITS(4), .LATENCY(1)) dut1 (
    .clock(clk), .reset(reset1), .read(read1), .write(write1),
    .address(address1), .writedata(writedata1), .readdata(readdata1),
    .busywait(busywait1), .illegal_req(illegal_req1)
  );

  typedef struct {
    int           len;
    logic [127:0] rd;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] mem_m [0:(1<<DB)-1];
  logic [127:0] last_rd;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < (1<<DB); i++) mem_m[i] = '0;
    last_rd = '0;
    exp_q.delete();
    exp_q.push_back('{len: (1<<DB), rd: 128'h0});
  endfunction

  // Monitor: each busy run (reset-low cycles only) ends in a response to check.
  initial begin : monitor
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        run = 0;
      end else if (busywait === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 128'(run), 128'h0);
        end else begin
          e = exp_q.pop_front();
          chk("busy_len", 128'(run), 128'(e.len));
          chk("readdata", readdata, e.rd);
        end
        run = 0;
      end
    end
  end

  task automatic wait_init();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busywait === 1'b0) begin ok = 1'b1; break; end
    end
    chk("init_done", 128'(ok), 128'h1);
    @(posedge clk); #1;
  endtask

  // Starts in an idle cycle (just after a rising edge), returns in one.
  task automatic do_access(input bit is_wr, input logic [27:0] a, input logic [127:0] d,
                           input int abort_at, input int rst_at);
    int idx;
    idx = int'(a[DB-1:0]);
    read = !is_wr; write = is_wr; address = a; writedata = d;
    if (abort_at == 0 && rst_at == 0) begin
      if (is_wr) mem_m[idx] = d;
      else       last_rd = mem_m[idx];
      exp_q.push_back('{len: LAT, rd: last_rd});
    end else if (abort_at > 0) begin
      exp_q.push_back('{len: abort_at + 1, rd: last_rd});
    end
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      if (c == abort_at) begin
        read = 0; write = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        return;
      end
      if (c == rst_at) begin
        read = 0; write = 0; reset = 1;
        model_reset();
        @(posedge clk); #1;
        reset = 0;
        wait_init();
        return;
      end
      // Inputs after cycle 0 must not disturb the access.
      address = 28'($urandom); writedata = rnd128();
      if (c == LAT) begin
        read = 0; write = 0;
      end else begin
        case ($urandom_range(0, 2))
          0: begin read = 1; write = 0; end
          1: begin read = 0; write = 1; end
          default: begin read = 1; write = 1; end
        endcase
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [127:0] d0, d1, dl;
    logic [27:0]  a;
    int           n;
    reset = 1; read = 0; write = 0; address = '0; writedata = '0;
    reset1 = 1; read1 = 0; write1 = 0; address1 = '0; writedata1 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    wait_init();

    do_access(0, 28'h0000005, '0, 0, 0);
    d0 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    do_access(1, 28'h0000103, d0, 0, 0);
    do_access(0, 28'h0000003, '0, 0, 0);
    d1 = rnd128();
    do_access(1, 28'h0000010, d1, 0, 0);
    do_access(0, 28'h0000010, '0, 0, 0);
    do_access(0, 28'h0000020, '0, 0, 0);

    // Read held through RESP: second access starts right after one low cycle.
    exp_q.push_back('{len: LAT, rd: mem_m[8'h03]});
    exp_q.push_back('{len: LAT, rd: mem_m[8'h10]});
    last_rd = mem_m[8'h10];
    read = 1; write = 0; address = 28'h0000003;
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      if (c == LAT) address = 28'h0000010;
    end
    @(negedge clk); chk("held_resp_low", 128'(busywait), 128'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("held_restart", 128'(busywait), 128'h1);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      if (c == LAT) read = 0;
    end
    @(posedge clk); #1;

    do_access(1, 28'h0000010, rnd128(), 2, 0);
    do_access(0, 28'h0000010, '0, 0, 0);

    read = 1; write = 1;
    @(negedge clk);
    chk("illegal_busy", 128'(busywait), 128'h0);
    chk("illegal_pre", 128'(illegal_req), 128'h0);
    @(posedge clk); #1; read = 0; write = 0;
    @(negedge clk); chk("illegal_pulse", 128'(illegal_req), 128'h1);
    @(posedge clk); #1;
    @(negedge clk); chk("illegal_clear", 128'(illegal_req), 128'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      a = 28'($urandom);
      a[7:4] = 4'h0;
      do_access(1'($urandom_range(0, 1)), a, rnd128(),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LAT - 1)) : 0, 0);
    end

    do_access(1, 28'h0000003, rnd128(), 0, 0);
    do_access(0, 28'h0000003, '0, 0, 0);
    do_access(1, 28'h0000044, rnd128(), 0, 2);
    do_access(0, 28'h0000044, '0, 0, 0);
    do_access(0, 28'h0000003, '0, 0, 0);

    // LATENCY=1, DEPTH_BITS=4 instance
    reset1 = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busywait1 === 1'b1) n++;
      else break;
    end
    chk("l1_init_len", 128'(n), 128'd16);
    dl = rnd128();
    @(posedge clk); #1; write1 = 1; address1 = 28'h0000013; writedata1 = dl;
    @(negedge clk); chk("l1_wr_busy", 128'(busywait1), 128'h1);
    @(posedge clk); #1; write1 = 0; address1 = 28'h0000003; writedata1 = rnd128();
    @(negedge clk); chk("l1_wr_resp", 128'(busywait1), 128'h0);
    @(posedge clk); #1; read1 = 1; address1 = 28'h0000003;
    @(negedge clk); chk("l1_rd_busy", 128'(busywait1), 128'h1);
    @(posedge clk); #1; read1 = 0; address1 = 28'h0000007;
    @(negedge clk);
    chk("l1_rd_resp", 128'(busywait1), 128'h0);
    chk("l1_rdata", readdata1, dl);
    @(posedge clk); #1; read1 = 1;
    @(negedge clk); chk("l1_rd2_busy", 128'(busywait1), 128'h1);
    @(posedge clk); #1; read1 = 0;
    @(negedge clk); chk("l1_rdata_blank", readdata1, 128'h0);

    repeat (5) @(posedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
